// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 constants and request decode helpers for the load/store initiator
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR      = 2'd2,
    ST_DONE    = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // funct3[1:0] carries the access size for both loads and stores
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  // Misaligned address or an unused funct3 encoding for the access kind
  function automatic logic req_illegal(input logic       is_store,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
    logic bad_f3;
    logic misaligned;
    if (is_store) bad_f3 = (f3 > F3_W);
    else          bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    misaligned = ((f3_size(f3) == SZ_H) && addr_lo[0]) ||
                 ((f3_size(f3) == SZ_W) && (addr_lo != 2'd0));
    return bad_f3 || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store-merge and load extract/extend datapath
//
// Ports:
//   old_word  word read back from memory
//   wdata     store data (low byte/half used for SB/SH)
//   size      access size
//   byte_off  addr[1:0] of the request
//   funct3    load funct3, selects sign/zero extension
//   merged    old_word with the target lane replaced by wdata
//   rdata     aligned, extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  lsu_size_e   size,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] merged,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    merged = old_word;
    case (size)
      SZ_B:    merged[{byte_off, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    merged[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  always_comb begin
    lane_b = old_word[{byte_off, 3'b000} +: 8];
    lane_h = old_word[{byte_off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_W:    rdata = old_word;
      F3_BU:   rdata = {24'd0, lane_b};
      F3_HU:   rdata = {16'd0, lane_h};
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - single-outstanding RV32I load/store initiator for a word-wide data memory
//
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   req_valid_in/req_ready_out  request handshake (ready only when idle)
//   is_store_in, funct3_in      access kind and RV32I funct3
//   addr_in, wdata_in           byte address and store data
//   resp_valid_out              one-cycle response pulse
//   resp_rdata_out              extended load data (0 for stores/errors)
//   resp_err_out                misaligned or illegal funct3
//   mem_store_en_out            word write strobe
//   mem_load_en_out             word read strobe
//   mem_addr_out                word index, held for the whole access
//   mem_wdata_out, mem_rdata_in memory write/read data
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int LOAD_LATENCY = 1
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              is_store_in,
  input  logic [2:0]        funct3_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  output logic              resp_valid_out,
  output logic [31:0]       resp_rdata_out,
  output logic              resp_err_out,
  output logic              mem_store_en_out,
  output logic              mem_load_en_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in
);

  localparam int CNT_W = (LOAD_LATENCY < 1) ? 1 : $clog2(LOAD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_LATENCY);

  lsu_state_e       state;
  logic             is_store_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] lat_cnt;

  logic [31:0]      merged_word;
  logic [31:0]      load_word;
  logic             illegal;

  // Upper address bits only alias onto the implemented words
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_in[31:ADDR_W+2];

  assign illegal = req_illegal(is_store_in, funct3_in, addr_in[1:0]);

  // Datapath works on captured request fields so the RMW is immune to input changes
  lsu_align u_align (
    .old_word (mem_rdata_in),
    .wdata    (wdata_q),
    .size     (f3_size(f3_q)),
    .byte_off (off_q),
    .funct3   (f3_q),
    .merged   (merged_word),
    .rdata    (load_word)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= ST_IDLE;
      is_store_q       <= 1'b0;
      f3_q             <= 3'd0;
      off_q            <= 2'd0;
      wdata_q          <= 32'd0;
      lat_cnt          <= '0;
      req_ready_out    <= 1'b1;
      resp_valid_out   <= 1'b0;
      resp_rdata_out   <= 32'd0;
      resp_err_out     <= 1'b0;
      mem_store_en_out <= 1'b0;
      mem_load_en_out  <= 1'b0;
      mem_addr_out     <= '0;
      mem_wdata_out    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_in) begin
            is_store_q    <= is_store_in;
            f3_q          <= funct3_in;
            off_q         <= addr_in[1:0];
            wdata_q       <= wdata_in;
            lat_cnt       <= '0;
            mem_addr_out  <= addr_in[ADDR_W+1:2];
            req_ready_out <= 1'b0;
            if (illegal) begin
              state          <= ST_DONE;
              resp_valid_out <= 1'b1;
              resp_err_out   <= 1'b1;
              resp_rdata_out <= 32'd0;
            end else if (is_store_in && (f3_size(funct3_in) == SZ_W)) begin
              state            <= ST_WR;
              mem_store_en_out <= 1'b1;
              mem_wdata_out    <= wdata_in;
            end else begin
              // Loads and sub-word stores both start with a word read
              state           <= ST_RD_WAIT;
              mem_load_en_out <= 1'b1;
            end
          end
        end

        ST_RD_WAIT: begin
          mem_load_en_out <= 1'b0;
          if (lat_cnt == CNT_LAST) begin
            if (is_store_q) begin
              state            <= ST_WR;
              mem_store_en_out <= 1'b1;
              mem_wdata_out    <= merged_word;
            end else begin
              state          <= ST_DONE;
              resp_valid_out <= 1'b1;
              resp_rdata_out <= load_word;
            end
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        ST_WR: begin
          mem_store_en_out <= 1'b0;
          state            <= ST_DONE;
          resp_valid_out   <= 1'b1;
          resp_rdata_out   <= 32'd0;
          resp_err_out     <= 1'b0;
        end

        default: begin
          state          <= ST_IDLE;
          resp_valid_out <= 1'b0;
          resp_rdata_out <= 32'd0;
          resp_err_out   <= 1'b0;
          req_ready_out  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - scoreboard bench for the load/store initiator
module tb_lsu_mem_initiator;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          checks;
  int          errors;

  // LOAD_LATENCY=1 instance
  logic        req_valid, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_ready, resp_valid, resp_err, store_en, load_en;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [9:0]  mem_addr;

  // LOAD_LATENCY=3 instance
  logic        req_valid3, is_store3;
  logic [2:0]  funct3_3;
  logic [31:0] addr3, wdata3;
  logic        req_ready3, resp_valid3, resp_err3, store_en3, load_en3;
  logic [31:0] resp_rdata3, mem_wdata3, mem_rdata3;
  logic [9:0]  mem_addr3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  lsu_mem_initiator #(.ADDR_W(10), .LOAD_LATENCY(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .is_store_in(is_store), .funct3_in(funct3), .addr_in(addr), .wdata_in(wdata),
    .resp_valid_out(resp_valid), .resp_rdata_out(resp_rdata), .resp_err_out(resp_err),
    .mem_store_en_out(store_en), .mem_load_en_out(load_en),
    .mem_addr_out(mem_addr), .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata)
  );

  lsu_mem_initiator #(.ADDR_W(10), .LOAD_LATENCY(3)) dut3 (
    .clk_in(clk), .rst_n_in(rst_n),
    .req_valid_in(req_valid3), .req_ready_out(req_ready3),
    .is_store_in(is_store3), .funct3_in(funct3_3), .addr_in(addr3), .wdata_in(wdata3),
    .resp_valid_out(resp_valid3), .resp_rdata_out(resp_rdata3), .resp_err_out(resp_err3),
    .mem_store_en_out(store_en3), .mem_load_en_out(load_en3),
    .mem_addr_out(mem_addr3), .mem_wdata_out(mem_wdata3), .mem_rdata_in(mem_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: read data appears LOAD_LATENCY edges after the read strobe
  logic [31:0] mem  [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (store_en) mem[mem_addr] <= mem_wdata;
    pipe1 <= load_en ? mem[mem_addr] : 32'hBAD0BAD0;
    if (store_en3) mem3[mem_addr3] <= mem_wdata3;
    pipe3[0] <= load_en3 ? mem3[mem_addr3] : 32'hBAD0BAD0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata3 = pipe3[2];

  // Response side of the scoreboard
  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: cycle %0d rdata %h err %b, required no response", cyc, resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resp_rdata !== e.rdata || resp_err !== e.err || cyc !== e.cyc) begin
          errors++;
          $display("FAIL resp: got rdata %h err %b cycle %0d, required rdata %h err %b cycle %0d",
                   resp_rdata, resp_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  // One request on the latency-1 instance; checks strobes per cycle after accept
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input int ld_rel, input int st_rel,
                        input logic [31:0] exp_wd, input string name);
    int t;
    logic [31:0] av;
    logic [9:0] exp_a;
    av = a;
    exp_a = av[11:2];
    @(posedge clk); #1;
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin t = cyc; break; end
    end
    checks++;
    if (t < 0) begin
      errors++;
      $display("FAIL %s accept: ready never high within 20 cycles, required accept", name);
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{rdata: exp_rd, err: exp_err, cyc: t + lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int r = 1; r <= lat; r++) begin
      @(negedge clk);
      checks++;
      if (load_en !== (r == ld_rel) || store_en !== (r == st_rel) || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s strobes T+%0d: load_en %b store_en %b ready %b, required %b %b 0",
                 name, r, load_en, store_en, req_ready, (r == ld_rel), (r == st_rel));
      end
      if (load_en || store_en) begin
        checks++;
        if (mem_addr !== exp_a) begin
          errors++;
          $display("FAIL %s mem_addr T+%0d: got %h, required %h", name, r, mem_addr, exp_a);
        end
      end
      if (store_en) begin
        checks++;
        if (mem_wdata !== exp_wd) begin
          errors++;
          $display("FAIL %s mem_wdata: got %h, required %h", name, mem_wdata, exp_wd);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || load_en !== 1'b0 || store_en !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s finish: ready %b load_en %b store_en %b pending %0d, required 1 0 0 0",
               name, req_ready, load_en, store_en, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({req_ready, resp_valid, resp_err, store_en, load_en} !== 5'b10000 ||
        resp_rdata !== 32'd0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rdy/rv/err/st/ld %b rdata %h addr %h wdata %h, required 10000 0 0 0",
               {req_ready, resp_valid, resp_err, store_en, load_en}, resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_sw;
    do_req(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0, 0, 2, 0, 1, 32'hDEADBEEF, "sw");
    do_req(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 1, 0, 32'h0, "lw_after_sw");
  endtask

  task automatic test_loads;
    do_req(1, 3'd2, 32'h10, 32'h80F07F01, 32'd0, 0, 2, 0, 1, 32'h80F07F01, "sw_init");
    do_req(0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3, 1, 0, 32'h0, "lb_13");
    do_req(0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0, 3, 1, 0, 32'h0, "lbu_13");
    do_req(0, 3'd1, 32'h12, 32'h0, 32'hFFFF80F0, 0, 3, 1, 0, 32'h0, "lh_12");
    do_req(0, 3'd5, 32'h10, 32'h0, 32'h00007F01, 0, 3, 1, 0, 32'h0, "lhu_10");
    do_req(0, 3'd0, 32'h10, 32'h0, 32'h00000001, 0, 3, 1, 0, 32'h0, "lb_10");
    do_req(0, 3'd1, 32'h10, 32'h0, 32'h00007F01, 0, 3, 1, 0, 32'h0, "lh_10");
    do_req(0, 3'd4, 32'h12, 32'h0, 32'h000000F0, 0, 3, 1, 0, 32'h0, "lbu_12");
    do_req(0, 3'd5, 32'h12, 32'h0, 32'h000080F0, 0, 3, 1, 0, 32'h0, "lhu_12");
  endtask

  task automatic test_rmw;
    do_req(1, 3'd2, 32'h10, 32'h11223344, 32'd0, 0, 2, 0, 1, 32'h11223344, "sw_rmw_init");
    do_req(1, 3'd0, 32'h11, 32'h000000AB, 32'd0, 0, 4, 1, 3, 32'h1122AB44, "sb_11");
    do_req(1, 3'd1, 32'h12, 32'hFFFF5566, 32'd0, 0, 4, 1, 3, 32'h5566AB44, "sh_12");
    do_req(0, 3'd2, 32'h1010, 32'h0, 32'h5566AB44, 0, 3, 1, 0, 32'h0, "lw_wrap");
    do_req(1, 3'd0, 32'h13, 32'h123456EE, 32'd0, 0, 4, 1, 3, 32'hEE66AB44, "sb_13");
  endtask

  task automatic test_errors;
    do_req(0, 3'd2, 32'h12, 32'h0, 32'd0, 1, 1, 0, 0, 32'h0, "lw_mis");
    do_req(1, 3'd1, 32'h11, 32'h1234, 32'd0, 1, 1, 0, 0, 32'h0, "sh_mis");
    do_req(0, 3'd3, 32'h10, 32'h0, 32'd0, 1, 1, 0, 0, 32'h0, "ld_f3_3");
    do_req(0, 3'd6, 32'h10, 32'h0, 32'd0, 1, 1, 0, 0, 32'h0, "ld_f3_6");
    do_req(1, 3'd4, 32'h10, 32'h0, 32'd0, 1, 1, 0, 0, 32'h0, "st_f3_4");
    do_req(0, 3'd5, 32'h13, 32'h0, 32'd0, 1, 1, 0, 0, 32'h0, "lhu_mis");
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    @(posedge clk); #1;
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h10; wdata = 32'h0;
    t1 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin t1 = cyc; break; end
    end
    if (t1 < 0) begin
      checks++; errors++;
      $display("FAIL b2b accept1: never accepted, required accept");
      req_valid = 1'b0;
      return;
    end
    sb.push_back('{rdata: 32'hEE66AB44, err: 1'b0, cyc: t1 + 3});
    @(posedge clk); #1;
    funct3 = 3'd4; addr = 32'h11;
    t2 = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin t2 = cyc; break; end
    end
    checks++;
    if (t2 != t1 + 4) begin
      errors++;
      $display("FAIL b2b accept2: cycle %0d, required %0d", t2, t1 + 4);
    end
    if (t2 >= 0) sb.push_back('{rdata: 32'h000000AB, err: 1'b0, cyc: t2 + 3});
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL b2b drain: %0d responses pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_rmw;
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h10; wdata = 32'h77;
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin t = cyc; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (t < 0 || load_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid load_en: got %b accept %0d, required 1", load_en, t);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    checks++;
    if (store_en !== 1'b0 || load_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid next: st %b ld %b ready %b resp %b, required 0 0 1 0",
               store_en, load_en, req_ready, resp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      checks++;
      if (store_en !== 1'b0 || load_en !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid after %0d: st %b ld %b ready %b resp %b, required 0 0 1 0",
                 r, store_en, load_en, req_ready, resp_valid);
      end
    end
    do_req(0, 3'd2, 32'h10, 32'h0, 32'hEE66AB44, 0, 3, 1, 0, 32'h0, "lw_after_rst");
  endtask

  task automatic test_latency3;
    int t;
    int resp_rel;
    @(posedge clk); #1;
    req_valid3 = 1'b1; is_store3 = 1'b0; funct3_3 = 3'd0; addr3 = 32'h13;
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready3) begin t = cyc; break; end
    end
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    resp_rel = -1;
    for (int r = 1; r <= 7; r++) begin
      @(negedge clk);
      checks++;
      if (load_en3 !== (r == 1) || store_en3 !== 1'b0) begin
        errors++;
        $display("FAIL lat3 strobes T+%0d: ld %b st %b, required %b 0", r, load_en3, store_en3, (r == 1));
      end
      if (resp_valid3) begin
        resp_rel = r;
        checks++;
        if (resp_rdata3 !== 32'hFFFFFF80 || resp_err3 !== 1'b0) begin
          errors++;
          $display("FAIL lat3 data: rdata %h err %b, required ffffff80 0", resp_rdata3, resp_err3);
        end
      end
    end
    checks++;
    if (t < 0 || resp_rel != 5) begin
      errors++;
      $display("FAIL lat3 timing: response at T+%0d (accept %0d), required T+5", resp_rel, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    req_valid = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
    req_valid3 = 0; is_store3 = 0; funct3_3 = 0; addr3 = 0; wdata3 = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'd0;
      mem3[i] = 32'd0;
    end
    mem3[4] = 32'h80F07F01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_sw();
    test_loads();
    test_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    test_latency3();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Core-side load/store initiator that drives the word-wide data memory (store enable, load enable, word address, store data, read data).
- Accepts one RV32I load/store request at a time from the execute stage.
- Detects misalignment and returns aligned, sign- or zero-extended load data.
- The memory writes whole words only, so SB/SH are done as read-modify-write (RMW).

Parameters:
- ADDR_W, 10, memory word-index width (1024 words); mem_addr_out = addr[ADDR_W+1:2].
- LOAD_LATENCY, 1, cycles from the mem_load_en_out cycle to valid mem_rdata_in (>=1).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- req_valid_in  input  1  core request valid.
- req_ready_out  output  1  block idle, can accept a request.
- is_store_in  input  1  1 = store, 0 = load.
- funct3_in  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- addr_in  input  32  byte address.
- wdata_in  input  32  store data (low bytes used for SB/SH).
- resp_valid_out  output  1  one-cycle response pulse.
- resp_rdata_out  output  32  extended load data; 0 for stores and errors.
- resp_err_out  output  1  misaligned or illegal funct3.
- mem_store_en_out  output  1  word write strobe.
- mem_load_en_out  output  1  word read strobe.
- mem_addr_out  output  ADDR_W  word index.
- mem_wdata_out  output  32  full word to write.
- mem_rdata_in  input  32  word read data.

Behaviour:
- Reset (asynchronous, rst_n_in=0):
  - FSM goes to IDLE; all outputs are 0 except req_ready_out=1.
  - Reset mid-operation abandons the access; no further strobes are issued.
- FSM states: IDLE, RD_WAIT, WR, DONE.
- Handshake:
  - req_ready_out=1 only in IDLE.
  - Accept on req_valid_in & req_ready_out in cycle T; all request fields are registered.
  - No response backpressure: resp_valid_out is high exactly one cycle, in DONE. DONE always returns to IDLE.
- Error check at accept:
  - H access with addr[0]=1, or W access with addr[1:0]!=0.
  - Load funct3 in {3,6,7}, or store funct3 > 2.
  - Result: IDLE->DONE, no memory strobe. Response at T+1 with resp_err_out=1 and rdata=0.
- SW: IDLE->WR.
  - T+1: mem_store_en_out=1, mem_wdata_out=wdata.
  - T+2: DONE.
- Loads: IDLE->RD_WAIT.
  - T+1: mem_load_en_out=1 for one cycle.
  - A counter waits LOAD_LATENCY cycles; mem_rdata_in is sampled at the end of cycle T+1+LOAD_LATENCY.
  - Then DONE; with LOAD_LATENCY=1 the response is at T+3.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- SB/SH: IDLE->RD_WAIT (read as for loads) -> WR -> DONE.
  - WR writes the captured word with only the target byte/half replaced by wdata[7:0]/[15:0].
  - With LOAD_LATENCY=1 the response is at T+4.
- mem_addr_out:
  - Valid whenever either strobe is high; held stable through the whole RMW.
  - Address bits above ADDR_W+1 are ignored (wraps).
- Strobe rules:
  - mem_store_en_out and mem_load_en_out are never high in the same cycle.
  - Each strobe is high at most one cycle per request.
- req_valid_in is ignored outside IDLE. No pipelining: one outstanding access.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/H/W/BU/HU.
  - FSM state encoding.
  - Access-size enum.
- Sub-module lsu_align, purely combinational:
  - store merge (old word, wdata, size, addr[1:0]) -> new word.
  - load extract/extend (word, funct3, addr[1:0]) -> rdata.
- The top level holds the FSM, request registers and latency counter.

Test Plan:
- Reset: rst_n_in low mid-RMW (during RD_WAIT) -> next cycle all strobes 0, req_ready_out=1, no resp_valid.
- SW addr 0x10, data 0xDEADBEEF at T -> T+1 store_en=1, mem_addr=4, wdata=0xDEADBEEF; T+2 resp_valid=1, err=0.
- Word 4 = 0x80F07F01:
  - LB addr 0x13 -> rdata 0xFFFFFF80 at T+3.
  - LBU addr 0x13 -> 0x00000080.
  - LH addr 0x12 -> 0xFFFF80F0.
  - LHU addr 0x10 -> 0x00007F01.
- SB: word 4 = 0x11223344, SB addr 0x11 data 0xAB -> load_en at T+1, store_en at T+3 with wdata 0x1122AB44, resp at T+4.
- Misaligned / illegal:
  - LW addr 0x12 -> resp at T+1, err=1, rdata 0, no strobes.
  - SH addr 0x11 -> same.
  - Load funct3=3 -> same.
- Back-to-back: req_valid held high with two requests -> second accepted only the cycle after DONE. A LOAD_LATENCY=3 build gives load response at T+5.
